// File: rtl/neander_mem_pkg.sv
// Shared types and defaults for the Neander memory responder and its RAM.
package neander_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/neander_ram_sp.sv
// Single-port-write / single-port-read synchronous RAM, read-first on collisions.
// Only the read register is reset; the array keeps its contents across reset.
module neander_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of the same array gives the pre-write value on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/neander_mem_responder.sv
// Memory responder: serves CPU reads/writes and accepts loader frames
// (address byte, then data bytes) that hold the CPU in reset while they land.
//
// state | meaning
// IDLE  | CPU owns the write port; a loader byte sets the frame address
// DATA  | loader bytes written at the pointer, CPU held, CPU writes dropped
// DONE  | single-cycle frame-complete pulse, loader stalled, CPU still held
module neander_mem_responder
  import neander_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_done
);

  ld_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ld_ready  = 1'b1;
    cpu_hold  = 1'b0;
    ld_done   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = mem_addr;
    ram_wdata = mem_data_out;

    case (state)
      IDLE: begin
        ram_we = mem_write;
        if (ld_valid) begin
          ptr_nxt   = ADDR_W'(ld_data);
          state_nxt = ld_last ? DONE : DATA;
        end
      end
      DATA: begin
        cpu_hold = 1'b1;
        if (ld_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ptr;
          ram_wdata = ld_data;
          ptr_nxt   = ptr + ADDR_W'(1);
          if (ld_last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        ld_ready  = 1'b0;
        cpu_hold  = 1'b1;
        ld_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset wins over any strobe: nothing reaches the array in a reset cycle.
  neander_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we & ~reset),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (mem_read),
    .raddr (mem_addr),
    .rdata (mem_data_in)
  );

endmodule

// File: tb/tb_neander_mem_responder.sv
// Scoreboard bench: reads push the reference-model byte, a monitor pops and compares.
`timescale 1ns/1ps
module tb_neander_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_out;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic       mem_read;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_hold;
  logic       ld_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  neander_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .cpu_hold     (cpu_hold),
    .ld_done      (ld_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read sampled at an edge must show its data right after that edge.
  always begin : monitor
    logic       issued;
    logic [7:0] e;
    @(posedge clk);
    issued = mem_read && !reset;
    #1;
    if (issued) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", mem_data_in, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {24'h0, mem_data_in}, {24'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_strobes();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit rdy, input bit hold, input bit done);
    chk({tag, "_ld_ready"}, {31'h0, ld_ready}, {31'h0, rdy});
    chk({tag, "_cpu_hold"}, {31'h0, cpu_hold}, {31'h0, hold});
    chk({tag, "_ld_done"},  {31'h0, ld_done},  {31'h0, done});
  endtask

  // CPU access outside any frame: writes always land in the model.
  task automatic cpu_op(input bit we, input bit re, input logic [7:0] a, input logic [7:0] d);
    mem_write    = we;
    mem_read     = re;
    mem_addr     = a;
    mem_data_out = d;
    if (re) exp_q.push_back(model[a]);
    if (we) model[a] = d;
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] bytes [$], input int gap_max,
                            input bit noise, output int hold_cnt, output int done_cnt);
    logic [7:0] p;
    int gaps;
    p = a;
    hold_cnt = 0;
    done_cnt = 0;
    check_status("pre", 1'b1, 1'b0, 1'b0);
    ld_valid = 1'b1;
    ld_data  = a;
    ld_last  = (bytes.size() == 0);
    @(negedge clk);
    clear_strobes();
    hold_cnt += int'(cpu_hold);
    done_cnt += int'(ld_done);
    if (bytes.size() == 0) check_status("empty", 1'b0, 1'b1, 1'b1);
    else                   check_status("addr",  1'b1, 1'b1, 1'b0);
    foreach (bytes[i]) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        if (noise) begin
          mem_read = 1'b1;
          mem_addr = 8'($urandom);
          exp_q.push_back(model[mem_addr]);
        end
        @(negedge clk);
        clear_strobes();
        hold_cnt += int'(cpu_hold);
        done_cnt += int'(ld_done);
        check_status("gap", 1'b1, 1'b1, 1'b0);
      end
      ld_valid = 1'b1;
      ld_data  = bytes[i];
      ld_last  = (i == bytes.size() - 1);
      if (noise) begin
        mem_write    = 1'b1;
        mem_addr     = 8'($urandom);
        mem_data_out = 8'($urandom);
        mem_read     = 1'($urandom);
        if (mem_read) exp_q.push_back(model[mem_addr]);
      end
      model[p] = bytes[i];
      p = p + 8'd1;
      @(negedge clk);
      clear_strobes();
      hold_cnt += int'(cpu_hold);
      done_cnt += int'(ld_done);
      if (i == bytes.size() - 1) check_status("last", 1'b0, 1'b1, 1'b1);
      else                       check_status("data", 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    hold_cnt += int'(cpu_hold);
    done_cnt += int'(ld_done);
    check_status("post", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] q [$];
    int h, d, n;
    bit we, re;

    reset = 1'b1;
    mem_addr = '0;
    mem_data_out = '0;
    ld_data = '0;
    clear_strobes();
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdata", {24'h0, mem_data_in}, 32'h0);
    check_status("reset", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) cpu_op(1'b1, 1'b0, 8'(i), 8'($urandom));

    q = {8'hA1, 8'hB2, 8'hC3};
    send_frame(8'h10, q, 0, 1'b0, h, d);
    chk("frame10_hold_cycles", h, 4);
    chk("frame10_done_pulses", d, 1);
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 1'b1, 8'h10 + 8'(i), 8'h00);

    q = {8'h11, 8'h22, 8'h33};
    send_frame(8'hFE, q, 0, 1'b0, h, d);
    cpu_op(1'b0, 1'b1, 8'hFE, 8'h00);
    cpu_op(1'b0, 1'b1, 8'hFF, 8'h00);
    cpu_op(1'b0, 1'b1, 8'h00, 8'h00);

    cpu_op(1'b1, 1'b0, 8'h40, 8'h5A);
    cpu_op(1'b0, 1'b1, 8'h40, 8'h00);
    cpu_op(1'b1, 1'b1, 8'h40, 8'h77);
    cpu_op(1'b0, 1'b1, 8'h40, 8'h00);

    // CPU write attempted while the loader is in DATA must be dropped.
    ld_valid = 1'b1; ld_data = 8'h50; ld_last = 1'b0;
    @(negedge clk);
    clear_strobes();
    mem_write = 1'b1; mem_addr = 8'h20; mem_data_out = 8'h99;
    @(negedge clk);
    clear_strobes();
    ld_valid = 1'b1; ld_data = 8'h66; ld_last = 1'b1;
    model[8'h50] = 8'h66;
    @(negedge clk);
    clear_strobes();
    @(negedge clk);
    cpu_op(1'b0, 1'b1, 8'h20, 8'h00);
    cpu_op(1'b0, 1'b1, 8'h50, 8'h00);

    // Reset two bytes into a frame at 0x30, with a third byte and a CPU write pending.
    ld_valid = 1'b1; ld_data = 8'h30; ld_last = 1'b0;
    @(negedge clk);
    ld_data = 8'hD1; model[8'h30] = 8'hD1;
    @(negedge clk);
    ld_data = 8'hD2; model[8'h31] = 8'hD2;
    @(negedge clk);
    reset = 1'b1;
    ld_data = 8'hD3;
    mem_write = 1'b1; mem_read = 1'b1; mem_addr = 8'h32; mem_data_out = 8'hEE;
    @(negedge clk);
    reset = 1'b0;
    clear_strobes();
    check_status("midreset", 1'b1, 1'b0, 1'b0);
    chk("midreset_rdata", {24'h0, mem_data_in}, 32'h0);
    @(negedge clk);
    check_status("after_reset", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 1'b1, 8'h30 + 8'(i), 8'h00);

    repeat (40) begin
      if ($urandom_range(0, 2) == 0) begin
        q.delete();
        n = int'($urandom_range(0, 4));
        repeat (n) q.push_back(8'($urandom));
        send_frame(8'($urandom), q, 2, 1'b1, h, d);
        chk("rand_done_pulses", d, 1);
      end else begin
        we = 1'($urandom);
        re = !we || 1'($urandom);
        cpu_op(we, re, 8'($urandom), 8'($urandom));
      end
    end

    for (int i = 0; i < 256; i++) cpu_op(1'b0, 1'b1, 8'(i), 8'h00);

    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
